// File: rtl/pipe_stage.sv
// Elastic valid/ready pipeline register with synchronous flush and occupancy report.
// Define PIPE_STAGE_SKID_EN to add a second (skid) entry and a registered in_ready.
module pipe_stage #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state;
    logic [WIDTH-1:0] main_q;
    logic             accept;
    logic             emit;

    assign emit      = out_valid && out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign out_valid = (state != EMPTY);
    assign out_data  = out_valid ? main_q : BUBBLE;
    assign occupancy = state;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_q;
    logic             ready_q;

    // in_ready comes straight from a flop, so out_ready never reaches upstream combinationally.
    assign in_ready = ready_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            ready_q <= 1'b1;
        end else if (flush) begin
            state   <= EMPTY;
            skid_q  <= BUBBLE;
            ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept && emit) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        // Downstream stalled: park the new entry so main_q stays stable.
                        skid_q  <= in_data;
                        state   <= TWO;
                        ready_q <= 1'b0;
                    end else if (emit) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (emit) begin
                        main_q  <= skid_q;
                        skid_q  <= BUBBLE;
                        state   <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    // A slot frees up in the same cycle the held entry leaves.
    assign in_ready = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (accept) begin
                        main_q <= in_data;
                    end else if (emit) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: vector table, directed corner cases and a
// randomized run against a queue-based reference model. Follows PIPE_STAGE_SKID_EN.
module tb_pipe_stage;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam logic [31:0] BUBBLE = 32'h0;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the stage is a FIFO of capacity 1 (plain) or 2 (skid).
    logic [31:0] mq[$];

    pipe_stage #(.WIDTH(32), .BUBBLE(BUBBLE)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit expired, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_ready(input logic ordy);
        if (SKID) return (mq.size() < 2);
        return (mq.size() == 0) || ordy;
    endfunction

    task automatic model_check(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'(model_ready(out_ready)));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(mq.size() > 0));
        check({tag, ".out_data"},  out_data,       (mq.size() > 0) ? mq[0] : BUBBLE);
        check({tag, ".occupancy"}, 32'(occupancy), 32'(mq.size()));
    endtask

    // One cycle: drive at negedge, compare pre-edge outputs to the model, advance both on posedge.
    task automatic step(input string tag, input logic f, input logic iv,
                        input logic [31:0] id, input logic ordy);
        logic acc, emi;
        @(negedge CLK);
        flush = f; in_valid = iv; in_data = id; out_ready = ordy;
        #1;
        model_check(tag);
        acc = iv && model_ready(ordy) && !f;
        emi = (mq.size() > 0) && ordy;
        @(posedge CLK);
        if (f) begin
            mq.delete();
        end else begin
            if (emi) void'(mq.pop_front());
            if (acc) mq.push_back(id);
        end
    endtask

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [31:0] exp_out_data;
        logic [1:0]  exp_occ;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Streaming table: values 1..8 back to back, each seen one cycle later, then drain.
        for (int i = 0; i < 8; i++) begin
            tbl[i].flush         = 1'b0;
            tbl[i].in_valid      = 1'b1;
            tbl[i].in_data       = 32'(i + 1);
            tbl[i].out_ready     = 1'b1;
            tbl[i].exp_in_ready  = 1'b1;
            tbl[i].exp_out_valid = (i > 0);
            tbl[i].exp_out_data  = (i > 0) ? 32'(i) : BUBBLE;
            tbl[i].exp_occ       = (i > 0) ? 2'd1 : 2'd0;
        end
        tbl[8] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h8, 2'd1};
        tbl[9] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, BUBBLE, 2'd0};

        // Reset state.
        #12;
        check("reset.out_valid", 32'(out_valid), 32'h0);
        check("reset.out_data",  out_data,       BUBBLE);
        check("reset.occupancy", 32'(occupancy), 32'h0);
        check("reset.in_ready",  32'(in_ready),  32'h1);
        nRST = 1'b1;

        // First accept right after release, visible one edge later.
        step("release", 1'b0, 1'b1, 32'hA, 1'b0);
        #1;
        check("release.out_data",  out_data,       32'hA);
        check("release.out_valid", 32'(out_valid), 32'h1);
        step("clear", 1'b1, 1'b0, 32'h0, 1'b0);

        // Streaming table.
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            flush = tbl[i].flush; in_valid = tbl[i].in_valid;
            in_data = tbl[i].in_data; out_ready = tbl[i].out_ready;
            #1;
            check($sformatf("tbl[%0d].in_ready", i),  32'(in_ready),  32'(tbl[i].exp_in_ready));
            check($sformatf("tbl[%0d].out_valid", i), 32'(out_valid), 32'(tbl[i].exp_out_valid));
            check($sformatf("tbl[%0d].out_data", i),  out_data,       tbl[i].exp_out_data);
            check($sformatf("tbl[%0d].occupancy", i), 32'(occupancy), 32'(tbl[i].exp_occ));
            @(posedge CLK);
        end
        mq.delete();

        // Simultaneous accept and emit while holding one entry.
        step("ae.load", 1'b0, 1'b1, 32'h5, 1'b0);
        step("ae.both", 1'b0, 1'b1, 32'h6, 1'b1);
        #1;
        check("ae.out_data",  out_data,       32'h6);
        check("ae.occupancy", 32'(occupancy), 32'h1);
        step("ae.drain", 1'b0, 1'b0, 32'h0, 1'b1);

`ifdef PIPE_STAGE_SKID_EN
        // Backpressure: two entries fill the stage, the third waits upstream.
        step("bp.1", 1'b0, 1'b1, 32'h1, 1'b0);
        step("bp.2", 1'b0, 1'b1, 32'h2, 1'b0);
        step("bp.3", 1'b0, 1'b1, 32'h3, 1'b0);
        check("bp.full_occ",   32'(occupancy), 32'h2);
        check("bp.full_ready", 32'(in_ready),  32'h0);
        check("bp.head",       out_data,       32'h1);
        step("bp.e1", 1'b0, 1'b1, 32'h3, 1'b1);
        step("bp.e2", 1'b0, 1'b1, 32'h3, 1'b1);
        step("bp.e3", 1'b0, 1'b0, 32'h0, 1'b1);
        step("bp.idle", 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush while full drops both entries and the offered 0xF.
        step("fl.1", 1'b0, 1'b1, 32'hD, 1'b0);
        step("fl.2", 1'b0, 1'b1, 32'hE, 1'b0);
        step("fl.flush", 1'b1, 1'b1, 32'hF, 1'b0);
        #1;
        check("fl.out_valid", 32'(out_valid), 32'h0);
        check("fl.out_data",  out_data,       BUBBLE);
        check("fl.occupancy", 32'(occupancy), 32'h0);
        step("fl.after", 1'b0, 1'b0, 32'h0, 1'b1);
`else
        // in_ready follows out_ready within the same cycle.
        step("nr.load", 1'b0, 1'b1, 32'h7, 1'b0);
        @(negedge CLK);
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("nr.ready_low", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #1;
        check("nr.ready_high", 32'(in_ready), 32'h1);
        @(posedge CLK);
        void'(mq.pop_front());
        step("nr.idle", 1'b0, 1'b0, 32'h0, 1'b1);

        // Flush with an entry held and an offer pending.
        step("fl.1", 1'b0, 1'b1, 32'hD, 1'b0);
        step("fl.flush", 1'b1, 1'b1, 32'hF, 1'b0);
        #1;
        check("fl.out_valid", 32'(out_valid), 32'h0);
        check("fl.out_data",  out_data,       BUBBLE);
        check("fl.occupancy", 32'(occupancy), 32'h0);
`endif

        // Randomized traffic, with an asynchronous reset pulse partway through.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                @(negedge CLK);
                flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
                #1;
                nRST = 1'b0;
                #1;
                check("areset.out_valid", 32'(out_valid), 32'h0);
                check("areset.occupancy", 32'(occupancy), 32'h0);
                check("areset.out_data",  out_data,       BUBBLE);
                nRST = 1'b1;
                mq.delete();
            end
            step("rnd", ($urandom_range(15) == 0), $urandom_range(1) == 1, $urandom,
                 $urandom_range(3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
